mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-into-one arbiter that lets the instruction cache and data cache share a single `slow_memory` line port. It sits between the `CHIP` cache miss ports (`mem_*_I`, `mem_*_D`) and one `slow_memory` instance. It serializes line reads and writes with round-robin fairness, and it routes each returned line back to the requester that issued it. Saturating counters report grants and contention for performance analysis by the bench.

## Interface

- `ADDR_W`, default 28: line address width (byte address bits [31:4]).
- `DATA_W`, default 128: line width in bits.
- `CNT_W`, default 16: width of each statistics counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `i_read`  in  1  I-side line read request, held until `i_ready`.
- `i_addr`  in  ADDR_W  I-side line address.
- `i_ready`  out  1  one-cycle pulse: `i_rdata` is valid.
- `i_rdata`  out  DATA_W  line returned to the I side.
- `d_read`  in  1  D-side line read request, held until `d_ready`.
- `d_write`  in  1  D-side line write request, held until `d_ready`.
- `d_addr`  in  ADDR_W  D-side line address.
- `d_wdata`  in  DATA_W  D-side write line.
- `d_ready`  out  1  one-cycle pulse: D access complete; `d_rdata` is valid for a read.
- `d_rdata`  out  DATA_W  line returned to the D side.
- `mem_read`  out  1  read command to the slow memory.
- `mem_write`  out  1  write command to the slow memory.
- `mem_addr`  out  ADDR_W  memory line address.
- `mem_wdata`  out  DATA_W  memory write line.
- `mem_rdata`  in  DATA_W  memory read line, valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completion pulse.
- `grant_cnt_i`  out  CNT_W  number of I grants, saturating.
- `grant_cnt_d`  out  CNT_W  number of D grants, saturating.
- `conflict_cnt`  out  CNT_W  number of IDLE cycles in which both sides requested, saturating.

## Operation

- FSM states are IDLE, BUSY and RESP. A register `owner` records the granted side (I or D). A register `last` records the side granted most recently; it resets to I.
- IDLE, exactly one side requesting: grant that side.
- IDLE, both sides requesting: grant the side that is not `last`. Out of reset the D side therefore wins the first tie.
- On grant, the block latches the command, address and write data into the `mem_*` output registers, sets `owner` and `last`, and moves to BUSY.
- A D-side request counts as a write if `d_write` is 1, including when `d_read` is also 1. Otherwise it is a read. An I-side grant is always a read.
- BUSY: `mem_read`/`mem_write` stay held and the inputs are not resampled. On `mem_ready`, the block captures `mem_rdata` into the owner's rdata register and moves to RESP. The capture also happens for writes, in which case the data is don't-care.
- RESP: the owner's ready output is 1 for exactly this cycle, and `mem_read`/`mem_write` are 0. The next state is IDLE.
- The requester drops or changes its request on the edge that ends RESP. Requests sampled in the IDLE cycle that follows are therefore fresh.
- A `mem_ready` arriving outside BUSY is ignored.
- The rdata registers hold their value until the next capture for that side.
- Counters saturate at all-ones and never wrap. A grant increments its side's counter. `conflict_cnt` increments in every IDLE cycle where both sides are requesting.
- Reset, including mid-transaction, has the following effects:
  - The FSM returns to IDLE and `last` returns to I.
  - `mem_read`, `mem_write`, `i_ready` and `d_ready` go to 0.
  - `mem_addr`, `mem_wdata`, `i_rdata` and `d_rdata` go to 0.
  - All counters go to 0.
  - The in-flight access is abandoned and no ready pulse is issued for it.

## Timing

- All outputs are registered; there is no combinational path from any input to any output.
- Let the request be sampled in IDLE at cycle 0.
  - `mem_read`/`mem_write` are high from cycle 1.
  - If `mem_ready` is high in cycle k (k ≥ 1), then `mem_*` commands are low in cycle k+1 and requester ready plus rdata are valid in cycle k+1.
  - The FSM is back in IDLE at cycle k+2.
- Arbiter overhead is 2 cycles per access beyond the memory latency.
- The minimum spacing between two grants is 3 cycles, measured from IDLE through BUSY and RESP back to IDLE.
- Memory commands deassert for at least 1 cycle between consecutive accesses, which the slow memory handshake requires.

## Test plan

- Reset, then `i_read`=1 with `i_addr`=28'h0000010, and memory ready in cycle 4 with line 128'hA5…A5. Required: `mem_read` is high in cycles 1-4, `i_ready` pulses in cycle 5 with `i_rdata`=A5…A5, and `grant_cnt_i`=1.
- `d_write`=1 with `d_addr`=28'h0000200 and `d_wdata`=128'h1234. Required: `mem_write`=1 with address 200 and data 1234, `d_ready` pulses one cycle after `mem_ready`, and `mem_read` stays 0 throughout.
- First tie after reset, with `i_read` and `d_read` both held high. Required:
  - The D side is served first and the I side second.
  - `conflict_cnt`=1 after the first tie.
  - `i_ready` and `d_ready` are never high in the same cycle.
- Both sides request continuously for 6 accesses. Required: grants strictly alternate D, I, D, I, D, I, and each requester receives only its own lines.
- Assert `rst` while in BUSY, after which the memory returns `mem_ready`. Required: no ready pulse is issued, all outputs and counters are 0, and the next tie grants D.
- Preload `grant_cnt_i` to 16'hFFFE by running that many accesses or by forcing it, then perform 3 I accesses. Required: `grant_cnt_i` saturates and holds at 16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: I-cache and D-cache miss ports, the shared
// slow-memory line port, and the statistics counters.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic [CNT_W-1:0]  grant_cnt_i;
    logic [CNT_W-1:0]  grant_cnt_d;
    logic [CNT_W-1:0]  conflict_cnt;

    // arbiter side
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
        output grant_cnt_i, grant_cnt_d, conflict_cnt
    );

    // caches, memory and observers
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
        input  grant_cnt_i, grant_cnt_d, conflict_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow-memory line port between the I and D caches,
// with saturating grant/contention counters.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
    typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_e;

    state_e            state_q, state_d;
    side_e             owner_q, owner_d;
    side_e             last_q, last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]  grant_cnt_i_q, grant_cnt_i_d;
    logic [CNT_W-1:0]  grant_cnt_d_q, grant_cnt_d_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

    logic i_req_c;
    logic d_req_c;
    logic pick_d_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state, command latch, response capture and statistics
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        i_ready_d      = 1'b0;
        d_ready_d      = 1'b0;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        grant_cnt_i_d  = grant_cnt_i_q;
        grant_cnt_d_d  = grant_cnt_d_q;
        conflict_cnt_d = conflict_cnt_q;

        i_req_c  = bus.i_read;
        d_req_c  = bus.d_read | bus.d_write;
        // D wins when alone, or on a tie when I was served last
        pick_d_c = d_req_c & (~i_req_c | (last_q == SIDE_I));

        case (state_q)
            IDLE: begin
                if (i_req_c && d_req_c) begin
                    conflict_cnt_d = sat_inc(conflict_cnt_q);
                end
                if (i_req_c || d_req_c) begin
                    state_d = BUSY;
                    if (pick_d_c) begin
                        owner_d       = SIDE_D;
                        last_d        = SIDE_D;
                        mem_read_d    = ~bus.d_write;
                        mem_write_d   = bus.d_write;
                        mem_addr_d    = bus.d_addr;
                        mem_wdata_d   = bus.d_wdata;
                        grant_cnt_d_d = sat_inc(grant_cnt_d_q);
                    end else begin
                        owner_d       = SIDE_I;
                        last_d        = SIDE_I;
                        mem_read_d    = 1'b1;
                        mem_write_d   = 1'b0;
                        mem_addr_d    = bus.i_addr;
                        grant_cnt_i_d = sat_inc(grant_cnt_i_q);
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    state_d     = RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (owner_q == SIDE_D) begin
                        d_rdata_d = bus.mem_rdata;
                        d_ready_d = 1'b1;
                    end else begin
                        i_rdata_d = bus.mem_rdata;
                        i_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= SIDE_I;
            last_q         <= SIDE_I;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            i_ready_q      <= 1'b0;
            d_ready_q      <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            grant_cnt_i_q  <= '0;
            grant_cnt_d_q  <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            i_ready_q      <= i_ready_d;
            d_ready_q      <= d_ready_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            grant_cnt_i_q  <= grant_cnt_i_d;
            grant_cnt_d_q  <= grant_cnt_d_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.i_ready      = i_ready_q;
    assign bus.d_ready      = d_ready_q;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.grant_cnt_i  = grant_cnt_i_q;
    assign bus.grant_cnt_d  = grant_cnt_d_q;
    assign bus.conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cache requesters and a slow memory around the DUT, with a
// scoreboard monitor checking grant order, routing, data and counters.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = 16;
    localparam int          TMO    = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // slow memory environment
    logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];
    int mem_lat_cfg  = 0;
    int mem_last_lat = 0;
    bit mem_busy     = 1'b0;

    // reference model state
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] exp_i[$];
    bit                exp_dw[$];
    logic [DATA_W-1:0] exp_dd[$];
    bit                gq[$];
    bit                grant_log[$];
    bit                m_last = 1'b0;
    logic [CNT_W-1:0]  m_ci = '0;
    logic [CNT_W-1:0]  m_cd = '0;
    logic [CNT_W-1:0]  m_cc = '0;
    int                ready_cnt = 0;
    int                last_len  = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, DATA_W'(act), DATA_W'(exp));
    endtask

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return {4{{4'h0, a} ^ 32'hC3A5_0F96}};
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // slow memory: fixed or random latency, one-cycle ready pulse
    initial begin : memory
        int                lat;
        logic [ADDR_W-1:0] a;
        logic              w;
        logic [DATA_W-1:0] wd;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            if (bus.mem_read || bus.mem_write) begin
                mem_busy = 1'b1;
                lat = (mem_lat_cfg != 0) ? mem_lat_cfg : int'($urandom_range(1, 5));
                a   = bus.mem_addr;
                w   = bus.mem_write;
                wd  = bus.mem_wdata;
                repeat (lat - 1) begin @(posedge clk); #1; end
                if (w) begin
                    mem_arr[a]    = wd;
                    bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    bus.mem_rdata = mem_arr.exists(a) ? mem_arr[a] : pattern(a);
                end
                mem_last_lat  = lat;
                bus.mem_ready = 1'b1;
            end else begin
                mem_busy = 1'b0;
            end
        end
    end

    // monitor: grant fairness, command content, routing, data, counters
    initial begin : monitor
        bit                p_i, p_d, p_dw, p_cmd, p_mready, cmd, side, rside, dw;
        logic [ADDR_W-1:0] p_ia, p_da;
        logic [DATA_W-1:0] p_dwd, dd;
        int                cmd_len;
        p_i = 0; p_d = 0; p_dw = 0; p_cmd = 0; p_mready = 0; cmd_len = 0;
        p_ia = '0; p_da = '0; p_dwd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_i.delete(); exp_dw.delete(); exp_dd.delete();
                gq.delete(); grant_log.delete();
                m_last = 1'b0; m_ci = '0; m_cd = '0; m_cc = '0;
                p_i = 0; p_d = 0; p_cmd = 0; p_mready = 0; cmd_len = 0;
            end else begin
                cmd = bus.mem_read | bus.mem_write;
                if (cmd && !p_cmd) begin
                    check1("grant_had_request", p_i | p_d, 1'b1);
                    side = (p_i && p_d) ? ~m_last : p_d;
                    if (p_i && p_d) m_cc = sat(m_cc);
                    if (side) begin
                        m_cd = sat(m_cd);
                        check("grant_addr_d", DATA_W'(bus.mem_addr), DATA_W'(p_da));
                        check1("grant_write_d", bus.mem_write, p_dw);
                        check1("grant_read_d", bus.mem_read, ~p_dw);
                        if (p_dw) check("grant_wdata_d", bus.mem_wdata, p_dwd);
                    end else begin
                        m_ci = sat(m_ci);
                        check("grant_addr_i", DATA_W'(bus.mem_addr), DATA_W'(p_ia));
                        check1("grant_read_i", bus.mem_read, 1'b1);
                        check1("grant_write_i", bus.mem_write, 1'b0);
                    end
                    check("grant_cnt_i", DATA_W'(bus.grant_cnt_i), DATA_W'(m_ci));
                    check("grant_cnt_d", DATA_W'(bus.grant_cnt_d), DATA_W'(m_cd));
                    check("conflict_cnt", DATA_W'(bus.conflict_cnt), DATA_W'(m_cc));
                    m_last = side;
                    gq.push_back(side);
                    grant_log.push_back(side);
                end
                if (!cmd && p_cmd) begin
                    last_len = cmd_len;
                    check("cmd_length", DATA_W'(cmd_len), DATA_W'(mem_last_lat));
                end
                if (bus.i_ready && bus.d_ready) check1("both_ready", 1'b1, 1'b0);
                if (bus.i_ready || bus.d_ready) begin
                    ready_cnt++;
                    rside = bus.d_ready;
                    check1("ready_after_mem_ready", p_mready, 1'b1);
                    check1("cmd_low_in_resp", cmd, 1'b0);
                    if (gq.size() == 0) begin
                        check1("unexpected_ready", 1'b1, 1'b0);
                    end else begin
                        side = gq.pop_front();
                        check1("ready_side", rside, side);
                    end
                    if (!rside) begin
                        if (exp_i.size() == 0) check1("unexpected_i_ready", 1'b1, 1'b0);
                        else check("i_rdata", bus.i_rdata, exp_i.pop_front());
                    end else begin
                        if (exp_dw.size() == 0) begin
                            check1("unexpected_d_ready", 1'b1, 1'b0);
                        end else begin
                            dw = exp_dw.pop_front();
                            dd = exp_dd.pop_front();
                            if (!dw) check("d_rdata", bus.d_rdata, dd);
                        end
                    end
                end
                cmd_len  = cmd ? cmd_len + 1 : 0;
                p_cmd    = cmd;
                p_mready = bus.mem_ready;
                p_i      = bus.i_read;
                p_d      = bus.d_read | bus.d_write;
                p_dw     = bus.d_write;
                p_ia     = bus.i_addr;
                p_da     = bus.d_addr;
                p_dwd    = bus.d_wdata;
            end
        end
    end

    task automatic i_access(input logic [ADDR_W-1:0] a);
        int n;
        exp_i.push_back(ref_read(a));
        bus.i_read = 1'b1;
        bus.i_addr = a;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.i_ready && n < TMO);
        check1("i_ready_timeout", bus.i_ready, 1'b1);
        bus.i_read = 1'b0;
    endtask

    task automatic d_access(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        int n;
        exp_dw.push_back(wr);
        exp_dd.push_back(wr ? '0 : ref_read(a));
        if (wr) ref_mem[a] = wd;
        bus.d_read  = ~wr;
        bus.d_write = wr;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.d_ready && n < TMO);
        check1("d_ready_timeout", bus.d_ready, 1'b1);
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((mem_busy || bus.mem_read || bus.mem_write) && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        check1("quiet_timeout", n < TMO, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check1("rst_mem_read", bus.mem_read, 1'b0);
        check1("rst_mem_write", bus.mem_write, 1'b0);
        check1("rst_ready", bus.i_ready | bus.d_ready, 1'b0);
        check("rst_mem_addr", DATA_W'(bus.mem_addr), '0);
        check("rst_mem_wdata", bus.mem_wdata, '0);
        check("rst_rdata", bus.i_rdata | bus.d_rdata, '0);
        check("rst_counters", DATA_W'({bus.grant_cnt_i, bus.grant_cnt_d, bus.conflict_cnt}), '0);
        @(posedge clk); #1;
    endtask

    function automatic logic [ADDR_W-1:0] rand_i_addr();
        return ADDR_W'($urandom_range(0, 255));
    endfunction

    function automatic logic [ADDR_W-1:0] rand_d_addr();
        return ADDR_W'(32'h0800_0000 | $urandom_range(0, 7));
    endfunction

    function automatic logic [DATA_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : main
        int s0, rc0;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        mem_arr[ADDR_W'(28'h0000010)] = {16{8'hA5}};
        ref_mem[ADDR_W'(28'h0000010)] = {16{8'hA5}};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state();

        // single I read, memory ready in cycle 4
        mem_lat_cfg = 4;
        i_access(ADDR_W'(28'h0000010));
        check("t1_i_rdata", bus.i_rdata, {16{8'hA5}});
        check("t1_grant_cnt_i", DATA_W'(bus.grant_cnt_i), DATA_W'(1));
        wait_quiet();
        check("t1_cmd_len", DATA_W'(last_len), DATA_W'(4));

        // single D write, then read it back
        mem_lat_cfg = 3;
        d_access(1'b1, ADDR_W'(28'h0000200), DATA_W'(128'h1234));
        check("t2_grant_cnt_d", DATA_W'(bus.grant_cnt_d), DATA_W'(1));
        wait_quiet();
        mem_lat_cfg = 0;
        d_access(1'b0, ADDR_W'(28'h0000200), '0);
        check("t2_readback", bus.d_rdata, DATA_W'(128'h1234));
        wait_quiet();

        // first tie after reset goes to D
        do_reset();
        fork
            i_access(rand_i_addr());
            d_access(1'b0, rand_d_addr(), '0);
        join
        wait_quiet();
        check("t3_grants", DATA_W'(grant_log.size()), DATA_W'(2));
        if (grant_log.size() == 2) begin
            check1("t3_first_d", grant_log[0], 1'b1);
            check1("t3_second_i", grant_log[1], 1'b0);
        end
        check("t3_conflict", DATA_W'(bus.conflict_cnt), DATA_W'(1));

        // continuous contention alternates D, I, D, I, D, I
        s0 = grant_log.size();
        fork
            repeat (3) i_access(rand_i_addr());
            repeat (3) d_access(1'($urandom_range(0, 1)), rand_d_addr(), rand_line());
        join
        wait_quiet();
        check("t4_grants", DATA_W'(grant_log.size() - s0), DATA_W'(6));
        if (grant_log.size() == s0 + 6) begin
            for (int k = 0; k < 6; k++) check1("t4_alternate", grant_log[s0 + k], (k % 2) == 0);
        end

        // randomized traffic
        fork
            repeat (30) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                i_access(rand_i_addr());
            end
            repeat (30) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                d_access(1'($urandom_range(0, 1)), rand_d_addr(), rand_line());
            end
        join
        wait_quiet();

        // reset while BUSY abandons the access
        mem_lat_cfg = 6;
        bus.i_read  = 1'b1;
        bus.i_addr  = rand_i_addr();
        begin
            int n;
            n = 0;
            while (!bus.mem_read && n < TMO) begin @(posedge clk); #1; n++; end
            check1("t5_busy_reached", bus.mem_read, 1'b1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.i_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        rc0 = ready_cnt;
        check_reset_state();
        repeat (8) begin @(posedge clk); #1; end
        check("t5_no_ready", DATA_W'(ready_cnt), DATA_W'(rc0));
        wait_quiet();
        mem_lat_cfg = 0;
        fork
            i_access(rand_i_addr());
            d_access(1'b1, rand_d_addr(), rand_line());
        join
        wait_quiet();
        check("t5_grants", DATA_W'(grant_log.size()), DATA_W'(2));
        if (grant_log.size() > 0) check1("t5_tie_d", grant_log[0], 1'b1);

        // grant counter saturation
        @(negedge clk);
        force dut.grant_cnt_i_q = CNT_W'(16'hFFFE);
        m_ci = CNT_W'(16'hFFFE);
        @(posedge clk); #1;
        release dut.grant_cnt_i_q;
        @(negedge clk);
        check("t6_preload", DATA_W'(bus.grant_cnt_i), DATA_W'(16'hFFFE));
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            i_access(rand_i_addr());
            check("t6_saturate", DATA_W'(bus.grant_cnt_i), DATA_W'(16'hFFFF));
        end
        wait_quiet();

        check("drain_i", DATA_W'(exp_i.size()), '0);
        check("drain_d", DATA_W'(exp_dw.size()), '0);
        check("drain_grants", DATA_W'(gq.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
